// File: rtl/noc_pkg.sv
// Shared types and flit-field helpers for the mesh NoC router ports.
package noc_pkg;

  localparam int FLIT_W      = 16;
  localparam int COORD_W_DEF = 2;
  localparam int DEST_X_MSB  = FLIT_W - 1;
  localparam int DEST_Y_MSB  = DEST_X_MSB - COORD_W_DEF;

  typedef enum logic [2:0] {
    ROUTE_N = 3'd0,
    ROUTE_S = 3'd1,
    ROUTE_E = 3'd2,
    ROUTE_W = 3'd3,
    ROUTE_L = 3'd4
  } route_t;

  // Extracts a w-bit field whose top bit sits at msb; callers truncate to their width.
  function automatic logic [7:0] dest_field(input logic [FLIT_W-1:0] flit,
                                            input int msb, input int w);
    logic [FLIT_W-1:0] s;
    logic [7:0]        mask;
    s    = flit >> (msb - w + 1);
    mask = 8'((1 << w) - 1);
    return s[7:0] & mask;
  endfunction

endpackage

// File: rtl/noc_input_port_if.sv
// Link-side and crossbar-side signal bundle of one router input port.
// Handshake: a flit moves on a rising edge when link_valid_i && link_ready_o; the head is consumed when pop_req_i && valid_o.
interface noc_input_port_if
  import noc_pkg::*;
#(
  parameter int DEPTH = 4
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [FLIT_W-1:0] link_data_i;
  logic              link_valid_i;
  logic              link_ready_o;
  logic [FLIT_W-1:0] q_o;
  logic              valid_o;
  route_t            route_o;
  logic              pop_req_i;
  logic [CNT_W-1:0]  count_o;
  logic              pop_err_o;

  modport slave (
    input  link_data_i, link_valid_i, pop_req_i,
    output link_ready_o, q_o, valid_o, route_o, count_o, pop_err_o
  );

  modport master (
    output link_data_i, link_valid_i, pop_req_i,
    input  link_ready_o, q_o, valid_o, route_o, count_o, pop_err_o
  );
endinterface

// File: rtl/noc_route_calc.sv
// Combinational XY route decision for a flit arriving at router (X_ID, Y_ID).
module noc_route_calc
  import noc_pkg::*;
#(
  parameter int COORD_W = 2,
  parameter int X_ID    = 1,
  parameter int Y_ID    = 1
) (
  input  logic [FLIT_W-1:0] flit,
  output route_t            route
);
  localparam int DY_MSB = DEST_Y_MSB + COORD_W_DEF - COORD_W;
  localparam logic [COORD_W-1:0] X_C = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_ID);

  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;

  assign dest_x = COORD_W'(dest_field(flit, DEST_X_MSB, COORD_W));
  assign dest_y = COORD_W'(dest_field(flit, DY_MSB, COORD_W));

  // X is fully resolved before Y is considered, which keeps the mesh deadlock-free.
  always_comb begin
    route = ROUTE_L;
    if (dest_x > X_C)      route = ROUTE_E;
    else if (dest_x < X_C) route = ROUTE_W;
    else if (dest_y > Y_C) route = ROUTE_N;
    else if (dest_y < Y_C) route = ROUTE_S;
  end
endmodule

// File: rtl/noc_input_port.sv
// Router input port: flit FIFO with a parallel route array filled at push time.
module noc_input_port
  import noc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int COORD_W = 2,
  parameter int X_ID    = 1,
  parameter int Y_ID    = 1
) (
  input  logic            clk,
  input  logic            rst,
  noc_input_port_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [FLIT_W-1:0] data_mem [DEPTH];
  route_t            route_mem[DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop_err;
  route_t            push_route;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  noc_route_calc #(
    .COORD_W (COORD_W),
    .X_ID    (X_ID),
    .Y_ID    (Y_ID)
  ) u_route_calc (
    .flit  (bus.link_data_i),
    .route (push_route)
  );

  // Full/empty come from registered count only, so a pop never frees a slot in the same cycle.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.link_valid_i && !full;
  assign pop   = bus.pop_req_i && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i]  <= '0;
        route_mem[i] <= ROUTE_N;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pop_err <= 1'b0;
    end else begin
      if (push) begin
        data_mem[wr_ptr]  <= bus.link_data_i;
        route_mem[wr_ptr] <= push_route;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (bus.pop_req_i && empty) begin
        pop_err <= 1'b1;
      end
    end
  end

  assign bus.link_ready_o = !full;
  assign bus.valid_o      = !empty;
  assign bus.q_o          = data_mem[rd_ptr];
  assign bus.route_o      = route_mem[rd_ptr];
  assign bus.count_o      = count;
  assign bus.pop_err_o    = pop_err;
endmodule

// File: tb/tb_noc_input_port.sv
// Scoreboard bench for noc_input_port at router (1,1) with a 4-entry FIFO.
`timescale 1ns/1ps
module tb_noc_input_port;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  noc_input_port_if #(.DEPTH(DEPTH)) bus ();

  noc_input_port #(
    .DEPTH   (DEPTH),
    .COORD_W (2),
    .X_ID    (1),
    .Y_ID    (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [18:0] exp_q[$];   // {route[2:0], flit[15:0]}
  logic        model_err = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference XY route from the destination coordinates, router at (1,1).
  function automatic int ref_route(input logic [15:0] flit);
    int dx;
    int dy;
    dx = int'(flit) / 16384;
    dy = (int'(flit) / 4096) % 4;
    if (dx > 1) return 2;
    if (dx < 1) return 3;
    if (dy > 1) return 0;
    if (dy < 1) return 1;
    return 4;
  endfunction

  // Monitor: samples on the falling edge, mid-way between input updates.
  always @(negedge clk) begin
    int sz;
    logic [18:0] e;
    if (rst) begin
      exp_q.delete();
      model_err = 1'b0;
      chk("rst_valid", int'(bus.valid_o), 0);
      chk("rst_ready", int'(bus.link_ready_o), 1);
      chk("rst_count", int'(bus.count_o), 0);
      chk("rst_q", int'(bus.q_o), 0);
      chk("rst_route", int'(bus.route_o), 0);
      chk("rst_err", int'(bus.pop_err_o), 0);
    end else begin
      sz = exp_q.size();
      chk("count", int'(bus.count_o), sz);
      chk("valid", int'(bus.valid_o), int'(sz != 0));
      chk("ready", int'(bus.link_ready_o), int'(sz != DEPTH));
      chk("pop_err", int'(bus.pop_err_o), int'(model_err));
      if (bus.pop_req_i) begin
        if (sz > 0) begin
          e = exp_q.pop_front();
          chk("head_q", int'(bus.q_o), int'(e[15:0]));
          chk("head_route", int'(bus.route_o), int'(e[18:16]));
        end else begin
          model_err = 1'b1;
        end
      end
      if (bus.link_valid_i && sz != DEPTH) begin
        exp_q.push_back({3'(ref_route(bus.link_data_i)), bus.link_data_i});
      end
    end
  end

  // driver tasks: inputs change 1ns after the rising edge
  task automatic drive(input logic v, input logic [15:0] d, input logic p);
    bus.link_valid_i = v;
    bus.link_data_i  = d;
    bus.pop_req_i    = p;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(1'b0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] seq [4];
    seq[0] = 16'hC000; seq[1] = 16'h0000; seq[2] = 16'h6000; seq[3] = 16'h4000;
    rst = 1'b1;
    bus.link_valid_i = 1'b0;
    bus.link_data_i  = 16'h0;
    bus.pop_req_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single local flit
    drive(1'b1, 16'h5ABC, 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    chk("local_q", int'(bus.q_o), 16'h5ABC);
    chk("local_route", int'(bus.route_o), 4);
    drive(1'b0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 1'b0);

    // fill with E, W, N, S then keep offering while full
    for (int i = 0; i < 4; i++) drive(1'b1, seq[i], 1'b0);
    drive(1'b1, 16'h9123, 1'b0);
    drive(1'b1, 16'h9123, 1'b0);
    chk("full_ready", int'(bus.link_ready_o), 0);
    drive(1'b1, 16'h9123, 1'b1);
    chk("after_pop_count", int'(bus.count_o), 3);
    drive(1'b1, 16'h9123, 1'b0);
    chk("refill_count", int'(bus.count_o), 4);
    drain();

    // steady push+pop at count 2 across pointer wrap
    drive(1'b1, 16'h1111, 1'b0);
    drive(1'b1, 16'hE222, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 16'($urandom), 1'b1);
    chk("steady_count", int'(bus.count_o), 2);
    drain();

    // pop while empty
    drive(1'b0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 1'b0);
    chk("empty_pop_err", int'(bus.pop_err_o), 1);
    drive(1'b1, 16'h7ABC, 1'b0);
    drive(1'b0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 1'b0);

    // asynchronous reset with three flits stored
    for (int i = 0; i < 3; i++) drive(1'b1, 16'($urandom), 1'b0);
    bus.link_valid_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_valid", int'(bus.valid_o), 0);
    chk("async_count", int'(bus.count_o), 0);
    chk("async_ready", int'(bus.link_ready_o), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    chk("post_rst_valid", int'(bus.valid_o), 0);
    drive(1'b1, 16'h8ABC, 1'b0);
    drive(1'b0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    drain();
    chk("final_empty", int'(bus.count_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
